// File: rtl/uart_rx_axis_framer_pkg.sv
// Shared constants and helpers for the UART receive-side AXI-Stream framer.
package uart_axis_pkg;

    localparam int CHAR_BITS = 11;

    typedef enum logic {
        PEND_EMPTY,
        PEND_HOLD
    } pend_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int idle_cycles(input int clk_hz, input int baud, input int chars);
        return chars * CHAR_BITS * baud_div(clk_hz, baud);
    endfunction

    // FIFO entry is {last, data}
    function automatic int entry_bits(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/uart_rx_axis_framer_if.sv
// Receiver strobe input plus AXI-Stream master output of the framer.
interface uart_rx_axis_framer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;

    modport master (
        input  rx_data, rx_valid, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output rx_data, rx_valid, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/uart_rx_axis_framer_fifo.sv
// First-word-fall-through FIFO; head entry is visible combinationally, zero when empty.
module axis_fwft_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_en;
    logic          wr_en;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign pop_en = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en  = push && (!full || pop_en);

    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_axis_framer.sv
// Holds each received byte until its frame-end flag is known, then queues {last, data} for AXIS.
// tlast closes a frame on an idle gap or on the MAX_LEN-th byte; bytes hitting a full FIFO are counted and lost.
module uart_rx_axis_framer
    import uart_axis_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int IDLE_CYCLES = idle_cycles(50_000_000, 115_200, 2),
    parameter int MAX_LEN     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_rx_axis_framer_if.master    bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_count
);
    localparam int EW = entry_bits(WIDTH);
    localparam int TW = $clog2(IDLE_CYCLES + 1);
    localparam int FW = $clog2(MAX_LEN + 1);

    pend_state_t      state;
    pend_state_t      state_nxt;
    logic [WIDTH-1:0] pend_dat;
    logic [TW-1:0]    timer;
    logic [FW-1:0]    frame_len;
    logic             timeout;
    logic             push_req;
    logic             push_last;
    logic             wr_vld;
    logic [EW-1:0]    wr_dat;
    logic [EW-1:0]    head;
    logic             pop;
    logic             full;
    logic             empty;

    assign timeout = (timer == TW'(IDLE_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_last = 1'b0;
        unique case (state)
            PEND_EMPTY: begin
                if (bus.rx_valid) begin
                    state_nxt = PEND_HOLD;
                end
            end
            PEND_HOLD: begin
                // A new byte beats a coinciding timeout, so only the length limit can close the frame here.
                if (bus.rx_valid) begin
                    push_req  = 1'b1;
                    push_last = (frame_len == FW'(MAX_LEN - 1));
                end else if (timeout) begin
                    push_req  = 1'b1;
                    push_last = 1'b1;
                    state_nxt = PEND_EMPTY;
                end
            end
            default: state_nxt = PEND_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PEND_EMPTY;
            pend_dat   <= '0;
            timer      <= '0;
            frame_len  <= '0;
            wr_vld     <= 1'b0;
            wr_dat     <= '0;
            drop_count <= '0;
        end else begin
            state  <= state_nxt;
            wr_vld <= push_req;
            wr_dat <= {push_last, pend_dat};
            if (bus.rx_valid) begin
                pend_dat <= bus.rx_data;
                timer    <= '0;
            end else if (state == PEND_HOLD) begin
                timer <= timeout ? '0 : timer + 1'b1;
            end
            // Frame length tracks attempts, so a dropped closing byte still restarts the count.
            if (push_req) begin
                frame_len <= push_last ? '0 : frame_len + 1'b1;
            end
            if (wr_vld && full && !pop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign pop = bus.m_axis_tvalid && bus.m_axis_tready;

    axis_fwft_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_vld),
        .push_dat (wr_dat),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_level),
        .full     (full),
        .empty    (empty)
    );

    assign bus.m_axis_tvalid = !empty;
    assign bus.m_axis_tdata  = head[WIDTH-1:0];
    assign bus.m_axis_tlast  = head[WIDTH];
endmodule
